pc_fetch_unit: RTL
==================

// Module: pc_fetch_unit
// PURPOSE
//  - Program-counter stage directly upstream of instruction memory: owns the fetch PC, drives the IM address each cycle.
//  - Picks next PC among sequential, branch/jump target, exception entry and ERET return.
//  - Tracks branch-delay-slot status of the instruction being fetched, for the CP0 BD bit.
//  - Exports the link address (PC+8) used by jal/jalr.
// PARAMETERS
//  RESET_PC     32'h0000_3000  fetch address after reset
//  EXC_ENTRY    32'h0000_4180  exception handler entry address
// PORTS
//  clk             in   1   system clock, rising edge
//  reset           in   1   asynchronous, active-high reset
//  stall_i         in   1   hazard stall from D stage: hold PC and BD state
//  f_is_jump_i     in   1   predecode of instruction now in F: branch/jump (its successor is a delay slot)
//  br_taken_i      in   1   D-stage branch/jump resolved taken
//  br_target_i     in   32  D-stage branch/jump target
//  exc_req_i       in   1   exception/interrupt taken at M stage (CP0)
//  eret_req_i      in   1   eret committing at M stage
//  epc_i           in   32  return address from CP0 EPC
//  pc_o            out  32  current fetch address, to IM
//  pc_plus8_o      out  32  pc_o + 8, link address
//  bd_o            out  1   instruction at pc_o is in a branch delay slot
//  fetch_cnt_o     out  32  (PC_FETCH_CNT_EN only) instructions issued from F
//  redirect_cnt_o  out  32  (PC_FETCH_CNT_EN only) non-sequential PC loads
// BEHAVIOUR
//  - Reset (async, immediate): pc_o=RESET_PC, bd_o=0, counters=0. On deassertion, first fetch is at RESET_PC.
//  - Registered PC; pc_o, pc_plus8_o, bd_o are flop outputs or derived only from flops. IM sees a new address one cycle after the update decision.
//  - Per rising edge, strict priority:
//    1. exc_req_i:  pc<=EXC_ENTRY, bd<=0; overrides stall and eret.
//    2. eret_req_i: pc<=epc_i, bd<=0; overrides stall.
//    3. stall_i:    pc, bd held; br_taken_i ignored, since D re-presents the branch next cycle.
//    4. br_taken_i: pc<=br_target_i, bd<=0 (the target is not a slot; the slot already moved to D).
//    5. default:    pc<=pc+4, bd<=f_is_jump_i.
//  - Arithmetic: pc+4 and pc+8 are modulo 2^32, with silent wrap at 32'hFFFF_FFFC.
//  - No range or alignment check here. Misaligned or out-of-range targets, including epc_i, load as-is; IM flags AdEL downstream.
//  - exc_req_i and eret_req_i both high: exception wins, eret dropped.
//  - Branch whose delay slot is itself a jump (f_is_jump_i high in rule 4): bd<=0. Architecturally undefined; no assertion required.
//  - Reset mid-stall or mid-redirect: reset wins; no pending state survives it.
// CONFIGURATION
//  - Macro PC_FETCH_CNT_EN:
//    - defined: adds fetch_cnt_o, which increments on every edge not held by stall (rules 1,2,4,5), and redirect_cnt_o, which increments on rules 1,2,4.
//    - Both 32-bit and wrap to 0.
//    - undefined: both ports and counters absent; core behaviour unchanged.
// STRUCTURE
//  - Shared package or header: RESET_PC / EXC_ENTRY defaults and the address-map constants (IM base 0x3000, IM top 0x6FFC), so IM and this block agree.
//  - Optional sub-module npc_select: combinational priority mux from above, returning next_pc, next_bd and redirect flag.
//  - pc_fetch_unit keeps the flops and counters.
// TESTING
//  - Reset: assert reset with clk running -> pc_o=0x3000, bd_o=0, pc_plus8_o=0x3008. Release -> 0x3004, 0x3008 on successive edges.
//  - Delay slot: f_is_jump_i=1 at pc 0x3010 -> next pc 0x3014 with bd_o=1. Next cycle br_taken_i=1, target 0x3040 -> pc 0x3040, bd_o=0.
//  - Stall vs branch: stall_i=1 for 3 edges with br_taken_i=1 -> pc and bd frozen. stall_i=0 -> pc=br_target_i.
//  - Priority: exc_req_i, eret_req_i, stall_i, br_taken_i all high on one edge -> pc=0x4180, bd_o=0. Next edge, eret_req_i only with epc_i=0x3024 -> pc=0x3024.
//  - Edge cases:
//    - br_target_i=0x3002 -> pc_o=0x3002 loaded unchanged.
//    - pc=0xFFFF_FFFC, no events -> pc_o=0x0000_0000, pc_plus8_o wraps to 0x0000_0004.
//  - PC_FETCH_CNT_EN defined: 10 sequential edges, 2 stalls, 1 branch, 1 exception -> fetch_cnt_o=12, redirect_cnt_o=2. Reset clears both.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// Shared address map and next-PC source encoding for the fetch stage.
// Instruction memory and pc_fetch_unit both take their constants from here.
package pc_fetch_unit_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] IM_BASE       = 32'h0000_3000;
    localparam logic [31:0] IM_TOP        = 32'h0000_6FFC;

    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] LINK_OFFSET   = 32'd8;

    typedef enum logic [2:0] {
        SRC_EXC,
        SRC_ERET,
        SRC_HOLD,
        SRC_BRANCH,
        SRC_SEQ
    } npc_src_e;

endpackage

// File: rtl/pc_fetch_unit_npc_select.sv
// Combinational next-PC priority mux: exception, eret, stall, branch, sequential.
// redirect is set whenever the next PC is not simply pc+4 or a held value.
module npc_select
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY
) (
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic        stall,
    input  logic        f_is_jump,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic        next_bd,
    output logic        redirect
);

    npc_src_e src;

    always_comb begin
        src = SRC_SEQ;
        if (exc_req)
            src = SRC_EXC;
        else if (eret_req)
            src = SRC_ERET;
        else if (stall)
            src = SRC_HOLD;
        else if (br_taken)
            src = SRC_BRANCH;
    end

    // Redirect targets never sit in a delay slot; the slot has already moved to D.
    always_comb begin
        next_pc  = pc + PC_STEP;
        next_bd  = f_is_jump;
        redirect = 1'b0;
        case (src)
            SRC_EXC: begin
                next_pc  = EXC_ENTRY;
                next_bd  = 1'b0;
                redirect = 1'b1;
            end
            SRC_ERET: begin
                next_pc  = epc;
                next_bd  = 1'b0;
                redirect = 1'b1;
            end
            SRC_HOLD: begin
                next_pc  = pc;
                next_bd  = bd;
            end
            SRC_BRANCH: begin
                next_pc  = br_target;
                next_bd  = 1'b0;
                redirect = 1'b1;
            end
            default: begin
                next_pc  = pc + PC_STEP;
                next_bd  = f_is_jump;
            end
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter: holds PC and delay-slot flag, drives IM address and link address.
// Optional fetch/redirect counters are enabled by defining PC_FETCH_CNT_EN.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] EXC_ENTRY = DEF_EXC_ENTRY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        f_is_jump_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_req_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus8_o,
    output logic        bd_o
`ifdef PC_FETCH_CNT_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o
`endif
);

    logic [31:0] pc;
    logic        bd;
    logic [31:0] next_pc;
    logic        next_bd;
    logic        redirect;

    npc_select #(
        .EXC_ENTRY (EXC_ENTRY)
    ) u_npc_select (
        .pc        (pc),
        .bd        (bd),
        .stall     (stall_i),
        .f_is_jump (f_is_jump_i),
        .br_taken  (br_taken_i),
        .br_target (br_target_i),
        .exc_req   (exc_req_i),
        .eret_req  (eret_req_i),
        .epc       (epc_i),
        .next_pc   (next_pc),
        .next_bd   (next_bd),
        .redirect  (redirect)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            bd <= 1'b0;
        end else begin
            pc <= next_pc;
            bd <= next_bd;
        end
    end

    assign pc_o       = pc;
    assign pc_plus8_o = pc + LINK_OFFSET;
    assign bd_o       = bd;

`ifdef PC_FETCH_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] redirect_cnt;

    // Exception and eret override stall, so any redirect also counts as an issued fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt    <= 32'd0;
            redirect_cnt <= 32'd0;
        end else begin
            if (redirect || !stall_i)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect)
                redirect_cnt <= redirect_cnt + 32'd1;
        end
    end

    assign fetch_cnt_o    = fetch_cnt;
    assign redirect_cnt_o = redirect_cnt;
`endif

endmodule
